// File: rtl/ac97_pkg.sv
// Shared AC-link constants, slot geometry and link FSM states.
package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int TAG_BITS   = 16;
    localparam int SLOT_BITS  = 20;

    // Tag bit positions within slot 0 (bit 15 is sent first).
    localparam int TAG_VALID = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_PCM0  = 12;

    typedef enum logic [1:0] {
        RST_LOW,
        WAKE,
        RUN
    } link_state_t;

    // First frame bit of slot n (n = 1..12).
    function automatic int slot_off(input int n);
        return TAG_BITS + SLOT_BITS * (n - 1);
    endfunction

    // Frame vectors hold the first transmitted bit in the MSB.
    function automatic int slot_msb(input int n);
        return FRAME_BITS - 1 - slot_off(n);
    endfunction

endpackage

// File: rtl/ac97_frame_ser.sv
// Frame serializer: loads a 256-bit frame and shifts it out MSB first with SYNC
// registered on the same edge as SDATA_OUT.
module ac97_frame_ser
    import ac97_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  sync,
    output logic                  sdout,
    output logic                  frame_end
);

    logic [FRAME_BITS-1:0] shreg;
    logic [7:0]            bit_cnt;

    always_ff @(posedge clock) begin
        if (reset || !(active || load)) begin
            shreg   <= '0;
            bit_cnt <= '0;
            sync    <= 1'b0;
            sdout   <= 1'b0;
        end else if (load) begin
            shreg   <= {frame[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= '0;
            sync    <= 1'b1;
            sdout   <= frame[FRAME_BITS-1];
        end else begin
            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 8'd1;
            sync    <= (bit_cnt + 8'd1) < 8'(TAG_BITS);
            sdout   <= shreg[FRAME_BITS-1];
        end
    end

    assign frame_end = active && (bit_cnt == 8'hFF);

endmodule

// File: rtl/ac97_link_tx.sv
// AC-link output controller: codec reset/wake sequencing, command and PCM
// handshakes, and frame assembly. Define UNDERRUN_HOLD_EN to repeat the last samples on underrun.
module ac97_link_tx
    import ac97_pkg::*;
#(
    parameter int SAMPLE_W    = 20,
    parameter int NUM_CH      = 2,
    parameter int RST_CYCLES  = 500,
    parameter int WAKE_CYCLES = 256
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       ac97_rst_n,
    output logic                       sync,
    output logic                       sdout,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [6:0]                 cmd_addr,
    input  logic [15:0]                cmd_data,
    input  logic                       pcm_valid,
    output logic                       pcm_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0] pcm_data,
    output logic                       underrun,
    output logic                       link_up
);

    localparam int TAG_BASE = FRAME_BITS - TAG_BITS;

    link_state_t state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        frame0, frame_end, load, pcm_tag;
    logic [FRAME_BITS-1:0]      frame;
    logic [NUM_CH*SAMPLE_W-1:0] pcm_src;
    logic [SLOT_BITS-1:0]       slot_val;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RST_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 16'd1;
        ac97_rst_n = 1'b1;
        link_up    = 1'b0;
        frame0     = 1'b0;
        case (state)
            RST_LOW: begin
                ac97_rst_n = 1'b0;
                if (cnt == 16'(RST_CYCLES - 1)) begin
                    state_nxt = WAKE;
                    cnt_nxt   = '0;
                end
            end
            WAKE: begin
                // Frame 0 is loaded here so its bit 0 lines up with RUN entry.
                if (cnt == 16'(WAKE_CYCLES - 1)) begin
                    frame0    = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                link_up = 1'b1;
                cnt_nxt = '0;
            end
            default: begin
                state_nxt = RST_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign cmd_ready = frame_end && cmd_valid;
    assign pcm_ready = frame_end && pcm_valid;
    assign underrun  = frame_end && !pcm_valid;
    assign load      = frame0 || frame_end;

`ifdef UNDERRUN_HOLD_EN
    logic [NUM_CH*SAMPLE_W-1:0] pcm_last;

    always_ff @(posedge clock) begin
        if (reset)
            pcm_last <= '0;
        else if (pcm_ready)
            pcm_last <= pcm_data;
    end

    assign pcm_src = pcm_ready ? pcm_data : pcm_last;
    assign pcm_tag = 1'b1;
`else
    assign pcm_src = pcm_ready ? pcm_data : '0;
    assign pcm_tag = pcm_ready;
`endif

    always_comb begin
        frame    = '0;
        slot_val = '0;
        frame[TAG_BASE + TAG_VALID] = 1'b1;
        if (cmd_ready) begin
            frame[TAG_BASE + TAG_SLOT1] = 1'b1;
            frame[TAG_BASE + TAG_SLOT2] = 1'b1;
            frame[slot_msb(1) -: SLOT_BITS] = {1'b0, cmd_addr, 12'h000};
            frame[slot_msb(2) -: SLOT_BITS] = {cmd_data, 4'h0};
        end
        for (int k = 0; k < NUM_CH; k++) begin
            slot_val = '0;
            slot_val[SLOT_BITS-1 -: SAMPLE_W] = pcm_src[k*SAMPLE_W +: SAMPLE_W];
            frame[TAG_BASE + TAG_PCM0 - k]      = pcm_tag;
            frame[slot_msb(3 + k) -: SLOT_BITS] = slot_val;
        end
    end

    ac97_frame_ser u_ser (
        .clock     (clock),
        .reset     (reset),
        .active    (link_up),
        .load      (load),
        .frame     (frame),
        .sync      (sync),
        .sdout     (sdout),
        .frame_end (frame_end)
    );

endmodule
